// File: rtl/mov_sprite_engine.sv
// Multi-sprite lookup: NUM_SPRITES double-buffered slots, shared pattern RAM, 3-stage pixel pipeline.
// Optional mirroring (attr_hflip/attr_vflip) is built when MOV_SPRITE_FLIP_EN is defined.
module mov_sprite_engine #(
    parameter int NUM_SPRITES  = 8,
    parameter int NUM_PATTERNS = 64,
    parameter int SIZE_LOG2    = 4,
    parameter int PIXEL_BITS   = 2,
    parameter int COORD_W      = 10,
    localparam int PAT_W  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int ADDR_W = PAT_W + 2 * SIZE_LOG2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [COORD_W-1:0]    pix_x,
    input  logic [COORD_W-1:0]    pix_y,
    output logic                  out_valid,
    output logic [PIXEL_BITS-1:0] out,
    output logic                  men,
    output logic [IDX_W-1:0]      out_sprite,
    input  logic                  attr_we,
    input  logic [IDX_W-1:0]      attr_idx,
    input  logic [COORD_W-1:0]    attr_x,
    input  logic [COORD_W-1:0]    attr_y,
    input  logic [PAT_W-1:0]      attr_pat,
    input  logic                  attr_en,
`ifdef MOV_SPRITE_FLIP_EN
    input  logic                  attr_hflip,
    input  logic                  attr_vflip,
`endif
    input  logic                  pat_we,
    input  logic [ADDR_W-1:0]     pat_addr,
    input  logic [PIXEL_BITS-1:0] pat_data
);
    localparam int DEPTH = NUM_PATTERNS << (2 * SIZE_LOG2);

    // Assert asynchronously, release two clocks after resetn rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic [COORD_W-1:0]     sh_x_q   [NUM_SPRITES];
    logic [COORD_W-1:0]     sh_y_q   [NUM_SPRITES];
    logic [PAT_W-1:0]       sh_pat_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en_q;
    logic [COORD_W-1:0]     ac_x_q   [NUM_SPRITES];
    logic [COORD_W-1:0]     ac_y_q   [NUM_SPRITES];
    logic [PAT_W-1:0]       ac_pat_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] ac_en_q;
`ifdef MOV_SPRITE_FLIP_EN
    logic [NUM_SPRITES-1:0] sh_hf_q, sh_vf_q, ac_hf_q, ac_vf_q;
`endif

    // Commit copies the shadow as it was before any same-cycle write.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i] <= '0; sh_y_q[i] <= '0; sh_pat_q[i] <= '0;
                ac_x_q[i] <= '0; ac_y_q[i] <= '0; ac_pat_q[i] <= '0;
            end
            sh_en_q <= '0;
            ac_en_q <= '0;
`ifdef MOV_SPRITE_FLIP_EN
            sh_hf_q <= '0; sh_vf_q <= '0; ac_hf_q <= '0; ac_vf_q <= '0;
`endif
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    ac_x_q[i]   <= sh_x_q[i];
                    ac_y_q[i]   <= sh_y_q[i];
                    ac_pat_q[i] <= sh_pat_q[i];
                end
                ac_en_q <= sh_en_q;
`ifdef MOV_SPRITE_FLIP_EN
                ac_hf_q <= sh_hf_q;
                ac_vf_q <= sh_vf_q;
`endif
            end
            if (attr_we && (int'(attr_idx) < NUM_SPRITES)) begin
                sh_x_q[attr_idx]   <= attr_x;
                sh_y_q[attr_idx]   <= attr_y;
                sh_pat_q[attr_idx] <= attr_pat;
                sh_en_q[attr_idx]  <= attr_en;
`ifdef MOV_SPRITE_FLIP_EN
                sh_hf_q[attr_idx]  <= attr_hflip;
                sh_vf_q[attr_idx]  <= attr_vflip;
`endif
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_vec;
    logic [SIZE_LOG2-1:0]   dx_vec [NUM_SPRITES];
    logic [SIZE_LOG2-1:0]   dy_vec [NUM_SPRITES];

    // One extra bit on the differences so nothing wraps: off-screen parts are clipped.
    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
            logic [COORD_W:0] diff_x, diff_y;
            assign diff_x = {1'b0, pix_x} - {1'b0, ac_x_q[gi]};
            assign diff_y = {1'b0, pix_y} - {1'b0, ac_y_q[gi]};
            assign hit_vec[gi] = ac_en_q[gi]
                               && (pix_x >= ac_x_q[gi]) && (diff_x[COORD_W:SIZE_LOG2] == '0)
                               && (pix_y >= ac_y_q[gi]) && (diff_y[COORD_W:SIZE_LOG2] == '0);
`ifdef MOV_SPRITE_FLIP_EN
            assign dx_vec[gi] = ac_hf_q[gi] ? ~diff_x[SIZE_LOG2-1:0] : diff_x[SIZE_LOG2-1:0];
            assign dy_vec[gi] = ac_vf_q[gi] ? ~diff_y[SIZE_LOG2-1:0] : diff_y[SIZE_LOG2-1:0];
`else
            assign dx_vec[gi] = diff_x[SIZE_LOG2-1:0];
            assign dy_vec[gi] = diff_y[SIZE_LOG2-1:0];
`endif
        end
    endgenerate

    logic                 hit_d;
    logic [IDX_W-1:0]     win_d;
    logic [SIZE_LOG2-1:0] dx_d, dy_d;
    logic [PAT_W-1:0]     pat_d;

    always_comb begin
        hit_d = 1'b0;
        win_d = '0;
        dx_d  = '0;
        dy_d  = '0;
        pat_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_d = 1'b1;
                win_d = IDX_W'(i);
                dx_d  = dx_vec[i];
                dy_d  = dy_vec[i];
                pat_d = ac_pat_q[i];
            end
        end
    end

    logic                  s1_valid_q, s1_hit_q, s2_valid_q, s2_hit_q;
    logic [IDX_W-1:0]      s1_win_q, s2_win_q;
    logic [SIZE_LOG2-1:0]  s1_dx_q, s1_dy_q;
    logic [PAT_W-1:0]      s1_pat_q;
    logic                  out_valid_q, men_q;
    logic [PIXEL_BITS-1:0] out_q, ram_rdata_q;
    logic [IDX_W-1:0]      out_sprite_q;

    logic [PIXEL_BITS-1:0] pat_mem [DEPTH];
    logic [ADDR_W-1:0]     rd_addr;
    assign rd_addr = {s1_pat_q, s1_dy_q, s1_dx_q};

    always_ff @(posedge clock) begin
        if (pat_we) pat_mem[pat_addr] <= pat_data;
        ram_rdata_q <= pat_mem[rd_addr];
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_valid_q <= 1'b0; s1_hit_q <= 1'b0; s1_win_q <= '0;
            s1_dx_q <= '0; s1_dy_q <= '0; s1_pat_q <= '0;
            s2_valid_q <= 1'b0; s2_hit_q <= 1'b0; s2_win_q <= '0;
            out_valid_q <= 1'b0; out_q <= '0; men_q <= 1'b0; out_sprite_q <= '0;
        end else begin
            s1_valid_q  <= pix_valid;
            s1_hit_q    <= hit_d;
            s1_win_q    <= win_d;
            s1_dx_q     <= dx_d;
            s1_dy_q     <= dy_d;
            s1_pat_q    <= pat_d;
            s2_valid_q  <= s1_valid_q;
            s2_hit_q    <= s1_hit_q;
            s2_win_q    <= s1_win_q;
            out_valid_q <= s2_valid_q;
            // Pixel value 0 is transparent; the winner hides lower-priority sprites regardless.
            if (s2_valid_q) begin
                out_q        <= s2_hit_q ? ram_rdata_q : '0;
                men_q        <= s2_hit_q && (ram_rdata_q != '0);
                out_sprite_q <= s2_hit_q ? s2_win_q : '0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out        = out_q;
    assign men        = men_q;
    assign out_sprite = out_sprite_q;
endmodule

// File: tb/tb_mov_sprite_engine.sv
// Bench for mov_sprite_engine: reference model scoreboard plus directed literal checks.
module tb_mov_sprite_engine;
    localparam int NS = 8, NP = 64, SL = 4, PB = 2, CW = 10, PW = 6, IW = 3, AW = 14;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    logic frame_start = 1'b0, pix_valid = 1'b0;
    logic [CW-1:0] pix_x = '0, pix_y = '0;
    logic out_valid, men;
    logic [PB-1:0] out;
    logic [IW-1:0] out_sprite;
    logic attr_we = 1'b0, attr_en = 1'b0;
    logic [IW-1:0] attr_idx = '0;
    logic [CW-1:0] attr_x = '0, attr_y = '0;
    logic [PW-1:0] attr_pat = '0;
`ifdef MOV_SPRITE_FLIP_EN
    logic attr_hflip = 1'b0, attr_vflip = 1'b0;
`endif
    logic pat_we = 1'b0;
    logic [AW-1:0] pat_addr = '0;
    logic [PB-1:0] pat_data = '0;

    always #5 clock = ~clock;

    mov_sprite_engine #(.NUM_SPRITES(NS), .NUM_PATTERNS(NP), .SIZE_LOG2(SL),
                        .PIXEL_BITS(PB), .COORD_W(CW)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .out_valid(out_valid), .out(out), .men(men), .out_sprite(out_sprite),
        .attr_we(attr_we), .attr_idx(attr_idx), .attr_x(attr_x), .attr_y(attr_y),
        .attr_pat(attr_pat), .attr_en(attr_en),
`ifdef MOV_SPRITE_FLIP_EN
        .attr_hflip(attr_hflip), .attr_vflip(attr_vflip),
`endif
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data)
    );

    int checks = 0, errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sprite tables, pattern memory, and expected results keyed by cycle.
    typedef struct {int rd_cyc; int out_cyc; bit hit; int win; int addr; int data;} ent_t;
    ent_t q[$];
    int m_sh_x[NS], m_sh_y[NS], m_sh_pat[NS], m_ac_x[NS], m_ac_y[NS], m_ac_pat[NS];
    bit m_sh_en[NS], m_sh_hf[NS], m_sh_vf[NS], m_ac_en[NS], m_ac_hf[NS], m_ac_vf[NS];
    int m_mem[NP*256];
    int cyc = 0;
    int h_out = 0, h_men = 0, h_spr = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NS; s++) begin
                m_sh_x[s] = 0; m_sh_y[s] = 0; m_sh_pat[s] = 0; m_sh_en[s] = 0;
                m_sh_hf[s] = 0; m_sh_vf[s] = 0;
                m_ac_x[s] = 0; m_ac_y[s] = 0; m_ac_pat[s] = 0; m_ac_en[s] = 0;
                m_ac_hf[s] = 0; m_ac_vf[s] = 0;
            end
            q.delete();
            h_out = 0; h_men = 0; h_spr = 0;
        end else begin
            cyc++;
            foreach (q[k]) if (q[k].rd_cyc == cyc) q[k].data = m_mem[q[k].addr];
            if (pat_we) m_mem[int'(pat_addr)] = int'(pat_data);
            if (pix_valid) begin
                ent_t e;
                int px, py, dx, dy;
                px = int'(pix_x); py = int'(pix_y);
                e.rd_cyc = cyc + 1; e.out_cyc = cyc + 2;
                e.hit = 0; e.win = 0; e.addr = 0; e.data = 0;
                for (int s = 0; s < NS; s++) begin
                    if (!e.hit && m_ac_en[s] && px >= m_ac_x[s] && px - m_ac_x[s] < 16
                        && py >= m_ac_y[s] && py - m_ac_y[s] < 16) begin
                        dx = px - m_ac_x[s]; dy = py - m_ac_y[s];
                        if (m_ac_hf[s]) dx = 15 - dx;
                        if (m_ac_vf[s]) dy = 15 - dy;
                        e.hit = 1; e.win = s; e.addr = m_ac_pat[s] * 256 + dy * 16 + dx;
                    end
                end
                q.push_back(e);
            end
            if (frame_start) begin
                m_ac_x = m_sh_x; m_ac_y = m_sh_y; m_ac_pat = m_sh_pat;
                m_ac_en = m_sh_en; m_ac_hf = m_sh_hf; m_ac_vf = m_sh_vf;
            end
            if (attr_we) begin
                m_sh_x[attr_idx] = int'(attr_x); m_sh_y[attr_idx] = int'(attr_y);
                m_sh_pat[attr_idx] = int'(attr_pat); m_sh_en[attr_idx] = attr_en;
`ifdef MOV_SPRITE_FLIP_EN
                m_sh_hf[attr_idx] = attr_hflip; m_sh_vf[attr_idx] = attr_vflip;
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].out_cyc == cyc) begin
                ent_t e;
                e = q.pop_front();
                h_out = e.hit ? e.data : 0;
                h_men = (e.hit && e.data != 0) ? 1 : 0;
                h_spr = e.hit ? e.win : 0;
                chk("mdl_valid", out_valid, 1);
                chk("mdl_out", out, h_out);
                chk("mdl_men", men, h_men);
                chk("mdl_sprite", out_sprite, h_spr);
            end else begin
                chk("mdl_idle", out_valid, 0);
                chk("mdl_hold_out", out, h_out);
                chk("mdl_hold_men", men, h_men);
                chk("mdl_hold_sprite", out_sprite, h_spr);
            end
        end
    end

    // All driver tasks are entered at a falling edge and leave at a falling edge.
    task automatic wr_attr(input int idx, input int x, input int y, input int pat,
                           input bit en, input bit hf, input bit vf, input bit fs);
        attr_we = 1; attr_idx = IW'(idx); attr_x = CW'(x); attr_y = CW'(y);
        attr_pat = PW'(pat); attr_en = en; frame_start = fs;
`ifdef MOV_SPRITE_FLIP_EN
        attr_hflip = hf; attr_vflip = vf;
`else
        if (hf || vf) $display("note: flip ignored in this build");
`endif
        @(negedge clock);
        attr_we = 0; frame_start = 0;
    endtask

    task automatic commit();
        frame_start = 1;
        @(negedge clock);
        frame_start = 0;
    endtask

    task automatic wr_pat(input int pat, input int row, input int col, input int d);
        pat_we = 1; pat_addr = AW'(pat * 256 + row * 16 + col); pat_data = PB'(d);
        @(negedge clock);
        pat_we = 0;
    endtask

    task automatic pix_check(input string name, input int x, input int y,
                             input int e_out, input int e_men, input int e_spr);
        pix_valid = 1; pix_x = CW'(x); pix_y = CW'(y);
        @(negedge clock);
        pix_valid = 0;
        @(negedge clock);
        chk({name, "_early"}, out_valid, 0);
        @(negedge clock);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_out"}, out, e_out);
        chk({name, "_men"}, men, e_men);
        chk({name, "_sprite"}, out_sprite, e_spr);
        $display("pixel (%0d,%0d): out=%0d men=%0d sprite=%0d", x, y, out, men, out_sprite);
    endtask

    int bx[5] = '{100, 200, 300, 400, 1012};
    int by[4] = '{50, 200, 300, 0};

    initial begin
        #1 resetn = 0;
        #1 chk_en = 1;
        repeat (3) @(negedge clock);
        #2 resetn = 1;
        repeat (5) @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_men", men, 0);
        chk("rst_sprite", out_sprite, 0);

        for (int a = 0; a < NP * 256; a++) begin
            pat_we = 1; pat_addr = AW'(a); pat_data = '0;
            @(negedge clock);
        end
        pat_we = 0;

        pix_check("empty", 10, 10, 0, 0, 0);

        wr_pat(5, 3, 7, 2);
        wr_attr(0, 100, 50, 5, 1, 0, 0, 0);
        commit();
        pix_check("basic", 107, 53, 2, 1, 0);

        wr_pat(7, 0, 0, 3);
        wr_attr(1, 200, 200, 6, 1, 0, 0, 0);
        wr_attr(3, 200, 200, 7, 1, 0, 0, 0);
        commit();
        pix_check("nofall", 200, 200, 0, 0, 1);
        wr_attr(1, 200, 200, 6, 0, 0, 0, 0);
        commit();
        pix_check("slot3", 200, 200, 3, 1, 3);

        wr_attr(2, 300, 300, 7, 1, 0, 0, 0);
        pix_check("shadow", 300, 300, 0, 0, 0);
        commit();
        pix_check("commit", 300, 300, 3, 1, 2);
        wr_attr(2, 400, 300, 7, 1, 0, 0, 1);
        pix_check("samecyc_new", 400, 300, 0, 0, 0);
        pix_check("samecyc_old", 300, 300, 3, 1, 2);
        commit();
        pix_check("late_commit", 400, 300, 3, 1, 2);

        for (int c = 0; c < 4; c++) wr_pat(8, 0, c, 1);
        wr_attr(4, 1020, 0, 8, 1, 0, 0, 0);
        commit();
        for (int k = 0; k < 4; k++) pix_check("right_edge", 1020 + k, 0, 1, 1, 4);
        pix_check("no_wrap", 4, 0, 0, 0, 0);

`ifdef MOV_SPRITE_FLIP_EN
        wr_pat(9, 0, 15, 3);
        wr_pat(9, 0, 0, 1);
        wr_attr(5, 500, 500, 9, 1, 1, 0, 0);
        commit();
        pix_check("hflip", 500, 500, 3, 1, 5);
`endif

        // Streaming: one pixel per cycle with attribute, commit and pattern traffic mixed in.
        for (int n = 0; n < 400; n++) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_x = CW'((bx[$urandom_range(0, 4)] + $urandom_range(0, 22)) % 1024);
            pix_y = CW'(by[$urandom_range(0, 3)] + $urandom_range(0, 18));
            pat_we = ($urandom_range(0, 3) == 0);
            pat_addr = AW'($urandom_range(5, 9) * 256 + $urandom_range(0, 255));
            pat_data = PB'($urandom_range(0, 3));
            attr_we = ($urandom_range(0, 7) == 0);
            attr_idx = IW'($urandom_range(0, NS - 1));
            attr_x = CW'(bx[$urandom_range(0, 4)] + $urandom_range(0, 8));
            attr_y = CW'(by[$urandom_range(0, 3)] + $urandom_range(0, 8));
            attr_pat = PW'($urandom_range(5, 9));
            attr_en = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 9) == 0);
            @(negedge clock);
        end
        pix_valid = 0; pat_we = 0; attr_we = 0; frame_start = 0;
        repeat (4) @(negedge clock);

        for (int n = 0; n < 3; n++) begin
            pix_valid = 1; pix_x = CW'(107); pix_y = CW'(53);
            @(negedge clock);
        end
        pix_valid = 0;
        #2 resetn = 0;
        @(negedge clock);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_men", men, 0);
        #2 resetn = 1;
        repeat (6) @(negedge clock);
        chk("post_rst_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mov_sprite_engine.md
Name: mov_sprite_engine

Overview:
- Parametrised successor to the single-pattern moving-sprite lookup: holds a table of NUM_SPRITES movable sprites, each with screen position, pattern index and enable.
- Per incoming screen pixel: finds the covering sprite, fetches its pixel from a shared writable pattern RAM, and returns colour plus mask enable (men) through a fixed 3-cycle pipeline.
- Attribute writes are double-buffered and committed on frame_start, so sprites never tear mid-frame.
- Sits between the VGA timing generator and the layer mixer.

Parameters:
NUM_SPRITES, 8, number of sprite slots (1..16)
NUM_PATTERNS, 64, patterns in pattern RAM; PAT_W = clog2(NUM_PATTERNS)
SIZE_LOG2, 4, sprite edge = 2^SIZE_LOG2 pixels (16x16)
PIXEL_BITS, 2, bits per pattern pixel
COORD_W, 10, screen coordinate width

Ports:
clock  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; commits shadow attributes to active
pix_valid  in  1  pix_x/pix_y valid this cycle
pix_x  in  COORD_W  screen column
pix_y  in  COORD_W  screen row
out_valid  out  1  pix_valid delayed 3 cycles
out  out  PIXEL_BITS  sprite pixel value
men  out  1  1 = sprite pixel opaque, mixer must use out
out_sprite  out  clog2(NUM_SPRITES)  index of winning sprite
attr_we  in  1  write shadow attribute slot
attr_idx  in  clog2(NUM_SPRITES)  slot index
attr_x  in  COORD_W  sprite left column
attr_y  in  COORD_W  sprite top row
attr_pat  in  PAT_W  pattern index
attr_en  in  1  sprite enable
pat_we  in  1  pattern RAM write
pat_addr  in  PAT_W+2*SIZE_LOG2  {pattern, row, column}
pat_data  in  PIXEL_BITS  pattern pixel

Behaviour:
- Reset (async, resetn=0): out_valid=0, out=0, men=0, out_sprite=0; all shadow and active slots cleared (x=0, y=0, pat=0, en=0). Pattern RAM contents are not reset. Release is synchronised to clock.
- Attributes: attr_we writes the shadow slot attr_idx. On frame_start, all active slots take the shadow values.
- attr_we and frame_start in the same cycle: the commit copies the pre-write shadow; the write lands in shadow only and is visible after the next frame_start.
- Stage 1, pix_valid registered, parallel hit test per active slot:
  - hit_i = en & pix_x>=x & (pix_x-x)<2^SIZE_LOG2 & pix_y>=y & (pix_y-y)<2^SIZE_LOG2.
  - Differences are unsigned with COORD_W+1 bits; no wrap, so sprites past the right/bottom edge are clipped.
  - Winner = lowest-index hitting slot. Register winner, hit flag, dx, dy (SIZE_LOG2 bits each) and pattern index.
- Stage 2: pattern RAM synchronous read at {pat, dy, dx}.
- Stage 3: out = RAM data when hit, else 0. men = hit & (data != 0): value 0 is transparent. out_sprite = winner when hit, else 0. out_valid = stage-3 valid.
- No fall-through: if the winning sprite's pixel is transparent, men=0 even when a higher-index sprite is opaque there.
- Latency: exactly 3 cycles from pix_valid to out_valid, fully pipelined, one pixel per cycle, no stalls. When out_valid=0, out, men and out_sprite hold their last values.
- Pattern RAM is single-clock, one write and one read port. Same-address write and read in one cycle returns old data. Writes are legal at any time and are not double-buffered.
- frame_start during in-flight pixels: pixels already past stage 1 keep their old attributes.
- Reset mid-operation: pipeline flushed, out_valid=0 on the next edge.

Optional Feature:
- Macro MOV_SPRITE_FLIP_EN.
- Defined:
  - Adds ports attr_hflip and attr_vflip (1 bit each), double-buffered like the other attributes.
  - Stage 1 uses dx' = 2^SIZE_LOG2-1-dx when hflip, and dy' = 2^SIZE_LOG2-1-dy when vflip.
- Undefined: ports absent, no mirroring logic.

Test Plan:
- Reset then pix_valid with no sprites enabled -> out_valid after 3 cycles, men=0, out=0.
- Pattern 5 pixel (row 3, col 7) = 2; slot 0 set to x=100, y=50, pat=5, en=1; frame_start; pixel (107,53) -> out=2, men=1, out_sprite=0, exactly 3 cycles later.
- Slots 1 and 3 overlap at (200,200), slot 1 pixel=0, slot 3 pixel=3 -> men=0, out_sprite=1. Disable slot 1 and commit -> out=3, out_sprite=3.
- Write slot 2 x=300 without frame_start -> no hit at 300; after frame_start -> hit. Check attr_we together with frame_start is not committed until the next frame_start.
- Sprite at x=1020 (COORD_W=10) -> hits for x=1020..1023; pixel x=4 does not hit.
- With MOV_SPRITE_FLIP_EN and hflip=1: pixel at dx=0 returns pattern column 15.
